// File: rtl/mem_ring_station.sv
// rtl/mem_ring_station.sv - Ring memory station: turns cache Address/WriteData slots into DDR line operations
// Read lines return on RDreturn/RDdest; one memory command is outstanding at a time.

module mem_ring_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             dropped
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = count == '0;
    assign full    = count == (AW+1)'(DEPTH);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push to a full FIFO is still accepted.
    assign do_push = push && (!full || do_pop);
    assign dropped = push && full && !do_pop;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

module mem_ring_station #(
    parameter int CMD_DEPTH = 8,
    parameter int WD_DEPTH  = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] RingIn,
    input  logic [3:0]  SlotTypeIn,
    input  logic [3:0]  SrcDestIn,
    output logic [31:0] RingOut,
    output logic [3:0]  SlotTypeOut,
    output logic [3:0]  SrcDestOut,
    output logic [31:0] RDreturn,
    output logic [3:0]  RDdest,
    output logic        mem_req,
    output logic        mem_write,
    output logic [27:0] mem_addr,
    input  logic        mem_ack,
    output logic [31:0] mem_wdata,
    output logic        mem_wvalid,
    input  logic        mem_wready,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid,
    output logic        overflow
);
    localparam logic [3:0] SLOT_ADDR  = 4'd2;
    localparam logic [3:0] SLOT_WDATA = 4'd3;
    localparam logic [3:0] SLOT_NULL  = 4'd7;

    typedef enum logic [1:0] {IDLE, ISSUE, WDATA, RDATA} state_t;

    state_t      state;
    logic [2:0]  beat;
    logic [3:0]  dest;

    logic [3:0]  op;
    logic        consume;
    logic        cmd_push;
    logic        cmd_pop;
    logic        wd_push;
    logic        wd_pop;
    logic [32:0] cmd_in;
    logic [32:0] cmd_head;
    logic        cmd_empty;
    logic        cmd_drop;
    logic [31:0] wd_head;
    logic        wd_empty;
    logic        wd_drop;

    assign op       = RingIn[31:28];
    assign consume  = (SlotTypeIn == SLOT_ADDR) || (SlotTypeIn == SLOT_WDATA);
    assign wd_push  = SlotTypeIn == SLOT_WDATA;
    // Only write-back, D read and I read are executed; other address commands are swallowed.
    assign cmd_push = (SlotTypeIn == SLOT_ADDR) &&
                      (op == 4'b0000 || op == 4'b0001 || op == 4'b0011);
    assign cmd_in   = {op == 4'b0000, RingIn[27:0], SrcDestIn};
    assign cmd_pop  = (state == IDLE) && !cmd_empty;

    assign mem_wvalid = (state == WDATA) && !wd_empty;
    assign mem_wdata  = wd_head;
    assign wd_pop     = mem_wvalid && mem_wready;

    mem_ring_fifo #(.WIDTH(33), .DEPTH(CMD_DEPTH)) cmd_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (cmd_push),
        .push_data (cmd_in),
        .pop       (cmd_pop),
        .head      (cmd_head),
        .empty     (cmd_empty),
        .dropped   (cmd_drop)
    );

    mem_ring_fifo #(.WIDTH(32), .DEPTH(WD_DEPTH)) wd_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (wd_push),
        .push_data (RingIn),
        .pop       (wd_pop),
        .head      (wd_head),
        .empty     (wd_empty),
        .dropped   (wd_drop)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            RingOut     <= '0;
            SlotTypeOut <= '0;
            SrcDestOut  <= '0;
        end else if (consume) begin
            RingOut     <= '0;
            SlotTypeOut <= SLOT_NULL;
            SrcDestOut  <= '0;
        end else begin
            RingOut     <= RingIn;
            SlotTypeOut <= SlotTypeIn;
            SrcDestOut  <= SrcDestIn;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (cmd_drop || wd_drop) begin
            overflow <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            beat      <= '0;
            dest      <= '0;
            mem_req   <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            RDreturn  <= '0;
            RDdest    <= '0;
        end else begin
            RDreturn <= '0;
            RDdest   <= '0;
            case (state)
                IDLE: begin
                    if (!cmd_empty) begin
                        mem_write <= cmd_head[32];
                        mem_addr  <= cmd_head[31:4];
                        dest      <= cmd_head[3:0];
                        mem_req   <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        beat    <= '0;
                        state   <= mem_write ? WDATA : RDATA;
                    end
                end
                WDATA: begin
                    if (wd_pop) begin
                        beat <= beat + 3'd1;
                        if (beat == 3'd7) state <= IDLE;
                    end
                end
                RDATA: begin
                    if (mem_rvalid) begin
                        RDreturn <= mem_rdata;
                        RDdest   <= dest;
                        beat     <= beat + 3'd1;
                        if (beat == 3'd7) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
